// File: rtl/imm_gen_pipe_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_pkg
//   Shared constants for the pipelined RISC-V immediate generator:
//     - 3-bit immediate format codes (IMM_FMT_*)
//     - RV32/RV64 base opcode constants (OPC_*)
//     - WORDSIZE, the raw instruction word width
//   Optional feature macro used by the importing files: IMMGEN_CSR_EN
// -----------------------------------------------------------------------------
package imm_gen_pipe_pkg;

   localparam int WORDSIZE = 32;

   typedef logic [2:0] imm_fmt_t;

   localparam imm_fmt_t IMM_FMT_R = 3'd0;
   localparam imm_fmt_t IMM_FMT_I = 3'd1;
   localparam imm_fmt_t IMM_FMT_S = 3'd2;
   localparam imm_fmt_t IMM_FMT_B = 3'd3;
   localparam imm_fmt_t IMM_FMT_U = 3'd4;
   localparam imm_fmt_t IMM_FMT_J = 3'd5;
   localparam imm_fmt_t IMM_FMT_Z = 3'd6;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_fmt_decode.sv
// -----------------------------------------------------------------------------
// imm_fmt_decode
//   Purely combinational opcode classifier used by stage 1 of imm_gen_pipe.
//   Maps the 7-bit major opcode (and funct3 for CSR immediates) to an
//   immediate format code and an illegal-opcode flag.
//   Optional feature: IMMGEN_CSR_EN -- SYSTEM with funct3[2]=1 decodes as
//   format Z (CSR zimm) instead of format I.
// Ports:
//   opcode  in  7  instr[6:0]
//   funct3  in  3  instr[14:12]
//   fmt     out 3  IMM_FMT_* code
//   illegal out 1  opcode not recognised (fmt is R then)
// -----------------------------------------------------------------------------
module imm_fmt_decode
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output imm_fmt_t   fmt,
   output logic       illegal
);

   // The W-suffixed opcodes only exist in RV64.
   localparam bit RV64 = (XLEN == 64);

   always_comb begin
      fmt     = IMM_FMT_R;
      illegal = 1'b0;
      case (opcode)
         OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR: fmt = IMM_FMT_I;
         OPC_SYSTEM: begin
`ifdef IMMGEN_CSR_EN
            fmt = funct3[2] ? IMM_FMT_Z : IMM_FMT_I;
`else
            fmt = IMM_FMT_I;
`endif
         end
         OPC_STORE:            fmt = IMM_FMT_S;
         OPC_BRANCH:           fmt = IMM_FMT_B;
         OPC_LUI, OPC_AUIPC:   fmt = IMM_FMT_U;
         OPC_JAL:              fmt = IMM_FMT_J;
         OPC_OP:               fmt = IMM_FMT_R;
         OPC_OP_IMM_32: begin
            fmt     = RV64 ? IMM_FMT_I : IMM_FMT_R;
            illegal = !RV64;
         end
         OPC_OP_32: begin
            fmt     = IMM_FMT_R;
            illegal = !RV64;
         end
         default: begin
            fmt     = IMM_FMT_R;
            illegal = 1'b1;
         end
      endcase
   end

`ifndef IMMGEN_CSR_EN
   // funct3 only matters for the CSR-immediate decode.
   logic unused_funct3;
   assign unused_funct3 = ^funct3;
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Two-stage pipelined RISC-V immediate generator with valid/ready on both
//   sides. Stage 1 registers the instruction, tag and the format decoded from
//   the opcode; stage 2 registers the assembled, sign-extended immediate and
//   drives every out_* port directly. Full throughput, two-cycle latency.
//   Optional feature: IMMGEN_CSR_EN -- CSRR*I encodings yield format Z with a
//   zero-extended 5-bit zimm; when undefined they are plain format I.
// Parameters:
//   XLEN   immediate width, 32 or 64
//   TAG_W  sideband tag width
// Ports:
//   clk, rst_n            clock (rising), asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_instr [31:0]       raw instruction word
//   in_tag   [TAG_W-1:0]  opaque sideband, returned on out_tag
//   out_valid/out_ready   downstream handshake
//   out_imm  [XLEN-1:0]   sign-extended immediate (0 for R and illegal)
//   out_fmt  [2:0]        format code R=0 I=1 S=2 B=3 U=4 J=5 Z=6
//   out_illegal           opcode not recognised
//   out_tag  [TAG_W-1:0]  tag of the same instruction
// -----------------------------------------------------------------------------
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORDSIZE-1:0] in_instr,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_imm,
   output logic [2:0]          out_fmt,
   output logic                out_illegal,
   output logic [TAG_W-1:0]    out_tag
);

   // Assemble the 32-bit immediate for a format, then widen to XLEN. The
   // intermediate is signed so the size cast replicates instr[31].
   function automatic logic [XLEN-1:0] build_imm(input logic [31:7] instr,
                                                 input imm_fmt_t    fmt);
      logic signed [31:0] imm32;
      logic [XLEN-1:0]    res;
      imm32 = '0;
      case (fmt)
         IMM_FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
         IMM_FMT_U: imm32 = {instr[31:12], 12'b0};
         IMM_FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
         default:   imm32 = '0;
      endcase
      res = XLEN'(imm32);
`ifdef IMMGEN_CSR_EN
      // zimm is unsigned: zero-extend rs1 field.
      if (fmt == IMM_FMT_Z) res = XLEN'(instr[19:15]);
`endif
      return res;
   endfunction

   imm_fmt_t          dec_fmt;
   logic              dec_ill;

   logic              vld_p1;
   logic [31:7]       instr_p1;
   logic [TAG_W-1:0]  tag_p1;
   imm_fmt_t          fmt_p1;
   logic              ill_p1;

   logic              vld_p2;
   logic [XLEN-1:0]   imm_p2;
   imm_fmt_t          fmt_p2;
   logic              ill_p2;
   logic [TAG_W-1:0]  tag_p2;

   logic              s1_adv;
   logic              s2_adv;

   assign s2_adv = !vld_p2 || out_ready;
   assign s1_adv = !vld_p1 || s2_adv;
   // Held low while reset is asserted so nothing is offered as accepted.
   assign in_ready = rst_n && s1_adv;

   imm_fmt_decode #(.XLEN(XLEN)) u_dec (
      .opcode  (in_instr[6:0]),
      .funct3  (in_instr[14:12]),
      .fmt     (dec_fmt),
      .illegal (dec_ill)
   );

   // ---- Stage 1: capture instruction, tag and decoded format ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         instr_p1 <= '0;
         tag_p1   <= '0;
         fmt_p1   <= IMM_FMT_R;
         ill_p1   <= 1'b0;
      end else if (s1_adv) begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            instr_p1 <= in_instr[31:7];
            tag_p1   <= in_tag;
            fmt_p1   <= dec_fmt;
            ill_p1   <= dec_ill;
         end
      end
   end

   // ---- Stage 2: assembled immediate, drives the outputs ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2 <= 1'b0;
         imm_p2 <= '0;
         fmt_p2 <= IMM_FMT_R;
         ill_p2 <= 1'b0;
         tag_p2 <= '0;
      end else if (s2_adv) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            imm_p2 <= build_imm(instr_p1, fmt_p1);
            fmt_p2 <= fmt_p1;
            ill_p2 <= ill_p1;
            tag_p2 <= tag_p1;
         end
      end
   end

   assign out_valid   = vld_p2;
   assign out_imm     = imm_p2;
   assign out_fmt     = fmt_p2;
   assign out_illegal = ill_p2;
   assign out_tag     = tag_p2;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised RISC-V immediate generator with valid/ready handshaking on both sides. It takes raw 32-bit instruction words and derives the immediate format from the opcode itself, with no `ops` select. It sign-extends every format (I/S/B/U/J, optionally CSR zimm) to XLEN and flags unsupported opcodes. It sits between fetch/decode and the register-read stage, at full throughput with fixed two-cycle latency.

## Interface
- `XLEN`, 32: immediate width; 32 or 64 only.
- `TAG_W`, 4: width of the sideband tag carried alongside each instruction.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: instruction offered.
- `in_ready` output 1: block accepts this cycle.
- `in_instr` input 32: raw instruction word.
- `in_tag` input TAG_W: opaque sideband.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts.
- `out_imm` output XLEN: sign-extended immediate.
- `out_fmt` output 3: format code (R=0, I=1, S=2, B=3, U=4, J=5, Z=6).
- `out_illegal` output 1: opcode not recognised.
- `out_tag` output TAG_W: `in_tag` of the same instruction.

## Operation
- Stage 1 (S1) registers the instruction and tag, plus the format decoded from `in_instr[6:0]`.
- Stage 2 (S2) registers the assembled immediate, format, illegal flag and tag. The S2 registers drive all `out_*` signals directly.
- Opcode to format:
  - LOAD 0000011, MISC-MEM 0001111, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011 → I.
  - STORE 0100011 → S.
  - BRANCH 1100011 → B.
  - LUI 0110111, AUIPC 0010111 → U.
  - JAL 1101111 → J.
  - OP 0110011 → R.
  - OP-IMM-32 0011011 → I, and OP-32 0111011 → R, when XLEN=64. When XLEN=32 both are illegal.
  - Every other opcode is illegal: fmt R, imm 0, `out_illegal`=1.
- Immediate assembly, each result sign-extended from `instr[31]` to XLEN:
  - I = `instr[31:20]`.
  - S = `{instr[31:25],instr[11:7]}`.
  - B = `{instr[31],instr[7],instr[30:25],instr[11:8],0}`.
  - U = `{instr[31:12],12'b0}`.
  - J = `{instr[31],instr[19:12],instr[20],instr[30:21],0}`.
  - R: imm = 0.
- Transfers occur only on valid&&ready. Tags and results leave in strict acceptance order; nothing is dropped or duplicated.

## Timing
- Reset: `in_ready` and all data outputs reset to 0 under `rst_n`, including `out_valid`, `out_imm`, `out_fmt`, `out_illegal` and `out_tag`. Internal valid bits also reset to 0.
- A reset assertion mid-stream discards all in-flight entries immediately (asynchronous). The first cycle after deassertion accepts new input.
- Latency: an instruction accepted at edge N appears on `out_*` after edge N+2 when downstream does not stall.
- Throughput: one instruction per cycle with `out_ready` held high.
- Handshake equations:
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv`.
- `in_ready` is combinational from `out_ready`; this is accepted, so no skid buffer is used.
- `out_*` stays stable while `out_valid && !out_ready`.
- Simultaneous S2 drain and S1 refill in the same cycle is legal and loses no bubble.
- `in_instr` and `in_tag` are ignored whenever `in_valid`=0.

## Configuration
- `IMMGEN_CSR_EN` defined: SYSTEM with `funct3[2]`=1 (CSRRWI/CSRRSI/CSRRCI) → fmt Z, imm = zero-extended `instr[19:15]`.
- `IMMGEN_CSR_EN` undefined: those encodings are fmt I with the normal sign-extended imm. Code 6 is never produced.

## Structure
- `defs.v` holds:
  - `IMM_FMT_R/I/S/B/U/J/Z` 3-bit codes.
  - RV opcode constants `OPC_*`.
  - The existing `WORDSIZE`.
- Sub-module `imm_fmt_decode` is purely combinational: opcode, funct3 → fmt, illegal. It is instantiated in S1.
- Immediate assembly stays in the top-level as a function parametrised on XLEN.

## Test plan
- Format coverage at XLEN=32:
  - `0xFFF00093` (addi x1,x0,-1) → imm 0xFFFFFFFF, fmt I.
  - `0xFE000EE3` (beq -4) → imm 0xFFFFFFFC, fmt B.
  - `0x123450B7` (lui) → imm 0x12345000, fmt U.
  - `0xFFFFF06F` (jal -2) → imm 0xFFFFFFFE, fmt J.
- Illegal and XLEN-dependent opcodes:
  - `0x0000007F` → `out_illegal`=1, imm 0, fmt R.
  - `0x0010009B` at XLEN=32 → illegal.
  - `0x0010009B` at XLEN=64 → imm 1, fmt I.
- XLEN=64 extension: `0xFFF00093` → imm 0xFFFFFFFF_FFFFFFFF.
- Backpressure: stream 6 back-to-back instructions with tags 0–5 while `out_ready`=0 for cycles 3–7.
  - `in_ready` drops once S1 and S2 are full.
  - All 6 tags emerge in order, with no loss or duplicates.
  - `out_*` is stable during the stall.
- Reset mid-operation: assert `rst_n`=0 with both stages full.
  - `out_valid` goes 0 immediately, with no clock edge needed.
  - After release, the next instruction emerges exactly 2 cycles after acceptance.
- CSR option: `0x3050D073` (csrrwi x0,mtvec,1).
  - With the macro: fmt Z, imm 1.
  - Without it: fmt I, imm 0x305.
